// File: rtl/data_bus_if.sv
// rtl/data_bus_if.sv - MEM-stage to Wishbone-classic data bus master
//
// Turns a single-cycle load/store request from the MEM stage into one
// registered Wishbone transaction. The pipeline is held with stallreq until
// the slave acknowledges or the timeout fires. Load data is buffered when the
// MEM stage is frozen, and a flush aborts any transaction in flight.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   stall_i[5:0]        pipeline stall vector (bit STALL_IDX freezes MEM)
//   flush_i             pipeline flush, aborts the transaction
//   cpu_ce_i/we_i       request valid / store(1) or load(0)
//   cpu_addr_i/sel_i    byte address / byte lane enables
//   cpu_data_i          store data
//   cpu_data_o          load data returned to the MEM stage
//   stallreq            pipeline stall request (combinational)
//   bus_err_o           one-cycle pulse when a transaction times out
//   wb_ack_i, wb_data_i slave acknowledge and read data
//   wb_addr_o, wb_data_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
//                       registered Wishbone master outputs

module data_bus_if #(
  parameter int STALL_IDX      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  input  logic        cpu_ce_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic [31:0] cpu_data_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq,
  output logic        bus_err_o,
  input  logic        wb_ack_i,
  input  logic [31:0] wb_data_i,
  output logic [31:0] wb_addr_o,
  output logic [31:0] wb_data_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BUSY       = 2'd1,
    WAIT_STALL = 2'd2
  } state_t;

  // The counter value at which the last BUSY cycle without ack is reached.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [31:0] rd_buf;
  logic [7:0]  cnt;

  logic mem_hold;
  logic timeout_hit;

  // Only one bit of the stall vector matters here; fold the rest away.
  logic stall_unused;
  assign stall_unused = ^stall_i;

  assign mem_hold    = stall_i[STALL_IDX];
  assign timeout_hit = (cnt == CNT_LAST);

  // ---------------------------------------------------------------------
  // Sequential state, Wishbone outputs, read buffer and error pulse
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rd_buf    <= 32'h0;
      cnt       <= 8'h0;
      bus_err_o <= 1'b0;
      wb_addr_o <= 32'h0;
      wb_data_o <= 32'h0;
      wb_we_o   <= 1'b0;
      wb_sel_o  <= 4'h0;
      wb_stb_o  <= 1'b0;
      wb_cyc_o  <= 1'b0;
    end else begin
      // bus_err_o is a pulse: it is only raised on the terminating edge.
      bus_err_o <= 1'b0;

      case (state)
        IDLE: begin
          if (flush_i) begin
            rd_buf <= 32'h0;
          end else if (cpu_ce_i) begin
            // The only edge where cpu_* inputs are sampled.
            wb_addr_o <= cpu_addr_i;
            wb_data_o <= cpu_data_i;
            wb_we_o   <= cpu_we_i;
            wb_sel_o  <= cpu_sel_i;
            wb_cyc_o  <= 1'b1;
            wb_stb_o  <= 1'b1;
            cnt       <= 8'h0;
            state     <= BUSY;
          end
        end

        BUSY: begin
          if (flush_i) begin
            // Flush beats a simultaneous ack or timeout.
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= 4'h0;
            rd_buf   <= 32'h0;
            state    <= IDLE;
          end else if (wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= 4'h0;
            rd_buf   <= wb_we_o ? 32'h0 : wb_data_i;
            state    <= mem_hold ? WAIT_STALL : IDLE;
          end else if (timeout_hit) begin
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_sel_o  <= 4'h0;
            rd_buf    <= 32'h0;
            bus_err_o <= 1'b1;
            state     <= mem_hold ? WAIT_STALL : IDLE;
          end else begin
            cnt <= cnt + 8'h1;
          end
        end

        WAIT_STALL: begin
          // Requests are ignored here; the MEM stage is still frozen on the
          // completed access and must see rd_buf until it advances.
          if (flush_i) begin
            rd_buf <= 32'h0;
            state  <= IDLE;
          end else if (!mem_hold) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Combinational pipeline interface
  // ---------------------------------------------------------------------
  always_comb begin
    stallreq   = 1'b0;
    cpu_data_o = 32'h0;
    if (!rst) begin
      case (state)
        IDLE: begin
          stallreq = cpu_ce_i & ~flush_i;
        end
        BUSY: begin
          if (flush_i) begin
            stallreq = 1'b0;
          end else if (wb_ack_i) begin
            // Forward read data in the ack cycle so a zero-wait slave
            // costs only the request cycle of stall.
            cpu_data_o = wb_we_o ? 32'h0 : wb_data_i;
          end else if (!timeout_hit) begin
            stallreq = 1'b1;
          end
        end
        WAIT_STALL: begin
          cpu_data_o = rd_buf;
        end
        default: begin
          stallreq   = 1'b0;
          cpu_data_o = 32'h0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_if.sv
// tb/tb_data_bus_if.sv - scoreboard testbench for data_bus_if
module tb_data_bus_if;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall_i = 6'h0;
  logic        flush_i = 1'b0;
  logic        cpu_ce_i = 1'b0;
  logic        cpu_we_i = 1'b0;
  logic [31:0] cpu_addr_i = 32'h0;
  logic [3:0]  cpu_sel_i = 4'h0;
  logic [31:0] cpu_data_i = 32'h0;
  logic [31:0] cpu_data_o;
  logic        stallreq;
  logic        bus_err_o;
  logic        wb_ack_i = 1'b0;
  logic [31:0] wb_data_i = 32'h0;
  logic [31:0] wb_addr_o;
  logic [31:0] wb_data_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;

  data_bus_if #(.STALL_IDX(4), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_sel_i(cpu_sel_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
    .stallreq(stallreq), .bus_err_o(bus_err_o), .wb_ack_i(wb_ack_i),
    .wb_data_i(wb_data_i), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
    .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o),
    .wb_cyc_o(wb_cyc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        sr;
    logic [31:0] cd;
    logic        bus;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wd;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   vec_id = 0;

  // Drive one cycle of inputs just after the rising edge. stl selects
  // stall_i[4]; the other stall bits are deliberately set when stl=0.
  task automatic drv(input logic rstv, input logic ce, input logic we,
                     input logic [31:0] addr, input logic [3:0] sel,
                     input logic [31:0] data, input logic stl,
                     input logic fl, input logic ak, input logic [31:0] rd);
    @(posedge clk);
    #1;
    cpu_ce_i   = ce;
    cpu_we_i   = we;
    cpu_addr_i = addr;
    cpu_sel_i  = sel;
    cpu_data_i = data;
    stall_i    = stl ? 6'b010000 : 6'b101111;
    flush_i    = fl;
    wb_ack_i   = ak;
    wb_data_i  = rd;
    rst        = rstv;
  endtask

  task automatic chk(input logic sr, input logic [31:0] cd, input logic bus,
                     input logic we, input logic [31:0] addr,
                     input logic [3:0] sel, input logic [31:0] wd,
                     input logic err);
    exp_t e;
    vec_id++;
    e.id = vec_id; e.sr = sr; e.cd = cd; e.bus = bus; e.we = we;
    e.addr = addr; e.sel = sel; e.wd = wd; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic idle_in(input logic rstv, input logic stl);
    drv(rstv, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, stl, 1'b0, 1'b0, 32'h0);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      if (stallreq !== e.sr || cpu_data_o !== e.cd || wb_cyc_o !== e.bus ||
          wb_stb_o !== e.bus || wb_we_o !== e.we || wb_addr_o !== e.addr ||
          wb_sel_o !== e.sel || wb_data_o !== e.wd || bus_err_o !== e.err) begin
        n_miss++;
        $display("FAIL vec%0d: got sr=%b cd=%h cyc=%b stb=%b we=%b addr=%h sel=%h wd=%h err=%b, want sr=%b cd=%h cyc/stb=%b we=%b addr=%h sel=%h wd=%h err=%b",
                 e.id, stallreq, cpu_data_o, wb_cyc_o, wb_stb_o, wb_we_o,
                 wb_addr_o, wb_sel_o, wb_data_o, bus_err_o,
                 e.sr, e.cd, e.bus, e.we, e.addr, e.sel, e.wd, e.err);
      end
    end
  end

  initial begin
    // Reset state, with a request present to show stallreq is gated.
    drv(1'b1, 1'b1, 1'b0, 32'h44, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk(0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 0);
    idle_in(1'b1, 1'b0); chk(0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 0);
    idle_in(1'b0, 1'b0); chk(0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 0);

    // Read, zero-wait ack, no stall.
    drv(0, 1, 0, 32'h100, 4'hF, 32'h0, 0, 0, 0, 32'h0);
    chk(1, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 0);
    drv(0, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 1, 32'hDEADBEEF);
    chk(0, 32'hDEADBEEF, 1, 0, 32'h100, 4'hF, 32'h0, 0);
    idle_in(0, 0); chk(0, 32'h0, 0, 0, 32'h100, 4'h0, 32'h0, 0);

    // Store, ack in third BUSY cycle; cpu_* scrambled while busy.
    drv(0, 1, 1, 32'h10, 4'h3, 32'h12345678, 0, 0, 0, 32'h0);
    chk(1, 32'h0, 0, 0, 32'h100, 4'h0, 32'h0, 0);
    drv(0, 0, 0, 32'hFFFF, 4'hF, 32'h99999999, 0, 0, 0, 32'h0);
    chk(1, 32'h0, 1, 1, 32'h10, 4'h3, 32'h12345678, 0);
    drv(0, 1, 0, 32'hFFFF, 4'hF, 32'h99999999, 0, 0, 0, 32'h0);
    chk(1, 32'h0, 1, 1, 32'h10, 4'h3, 32'h12345678, 0);
    drv(0, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 1, 32'hBAD0BAD0);
    chk(0, 32'h0, 1, 1, 32'h10, 4'h3, 32'h12345678, 0);
    idle_in(0, 0); chk(0, 32'h0, 0, 0, 32'h10, 4'h0, 32'h12345678, 0);

    // Read acked while MEM is stalled for 4 further cycles.
    drv(0, 1, 0, 32'h20, 4'hF, 32'h0, 0, 0, 0, 32'h0);
    chk(1, 32'h0, 0, 0, 32'h10, 4'h0, 32'h12345678, 0);
    drv(0, 0, 0, 32'h0, 4'h0, 32'h0, 1, 0, 1, 32'hA5A50001);
    chk(0, 32'hA5A50001, 1, 0, 32'h20, 4'hF, 32'h0, 0);
    idle_in(0, 1); chk(0, 32'hA5A50001, 0, 0, 32'h20, 4'h0, 32'h0, 0);
    drv(0, 1, 1, 32'h999, 4'hF, 32'h77, 1, 0, 0, 32'h0);
    chk(0, 32'hA5A50001, 0, 0, 32'h20, 4'h0, 32'h0, 0);
    idle_in(0, 1); chk(0, 32'hA5A50001, 0, 0, 32'h20, 4'h0, 32'h0, 0);
    idle_in(0, 1); chk(0, 32'hA5A50001, 0, 0, 32'h20, 4'h0, 32'h0, 0);
    idle_in(0, 0); chk(0, 32'hA5A50001, 0, 0, 32'h20, 4'h0, 32'h0, 0);
    idle_in(0, 0); chk(0, 32'h0, 0, 0, 32'h20, 4'h0, 32'h0, 0);

    // Flush together with ack in the second BUSY cycle: flush wins.
    drv(0, 1, 0, 32'h30, 4'hF, 32'h0, 0, 0, 0, 32'h0);
    chk(1, 32'h0, 0, 0, 32'h20, 4'h0, 32'h0, 0);
    idle_in(0, 0); chk(1, 32'h0, 1, 0, 32'h30, 4'hF, 32'h0, 0);
    drv(0, 0, 0, 32'h0, 4'h0, 32'h0, 0, 1, 1, 32'h11112222);
    chk(0, 32'h0, 1, 0, 32'h30, 4'hF, 32'h0, 0);
    idle_in(0, 0); chk(0, 32'h0, 0, 0, 32'h30, 4'h0, 32'h0, 0);
    // Flush in IDLE suppresses a request.
    drv(0, 1, 0, 32'h40, 4'hF, 32'h0, 0, 1, 0, 32'h0);
    chk(0, 32'h0, 0, 0, 32'h30, 4'h0, 32'h0, 0);
    idle_in(0, 0); chk(0, 32'h0, 0, 0, 32'h30, 4'h0, 32'h0, 0);

    // Timeout with no ack (TIMEOUT_CYCLES=4).
    drv(0, 1, 0, 32'h50, 4'h5, 32'h0, 0, 0, 0, 32'h0);
    chk(1, 32'h0, 0, 0, 32'h30, 4'h0, 32'h0, 0);
    idle_in(0, 0); chk(1, 32'h0, 1, 0, 32'h50, 4'h5, 32'h0, 0);
    idle_in(0, 0); chk(1, 32'h0, 1, 0, 32'h50, 4'h5, 32'h0, 0);
    idle_in(0, 0); chk(1, 32'h0, 1, 0, 32'h50, 4'h5, 32'h0, 0);
    idle_in(0, 0); chk(0, 32'h0, 1, 0, 32'h50, 4'h5, 32'h0, 0);
    idle_in(0, 0); chk(0, 32'h0, 0, 0, 32'h50, 4'h0, 32'h0, 1);
    idle_in(0, 0); chk(0, 32'h0, 0, 0, 32'h50, 4'h0, 32'h0, 0);

    // Ack on the last counter value beats timeout; stalled afterwards.
    drv(0, 1, 0, 32'h60, 4'hF, 32'h0, 0, 0, 0, 32'h0);
    chk(1, 32'h0, 0, 0, 32'h50, 4'h0, 32'h0, 0);
    idle_in(0, 0); chk(1, 32'h0, 1, 0, 32'h60, 4'hF, 32'h0, 0);
    idle_in(0, 0); chk(1, 32'h0, 1, 0, 32'h60, 4'hF, 32'h0, 0);
    idle_in(0, 0); chk(1, 32'h0, 1, 0, 32'h60, 4'hF, 32'h0, 0);
    drv(0, 0, 0, 32'h0, 4'h0, 32'h0, 1, 0, 1, 32'hCAFEF00D);
    chk(0, 32'hCAFEF00D, 1, 0, 32'h60, 4'hF, 32'h0, 0);
    idle_in(0, 0); chk(0, 32'hCAFEF00D, 0, 0, 32'h60, 4'h0, 32'h0, 0);
    idle_in(0, 0); chk(0, 32'h0, 0, 0, 32'h60, 4'h0, 32'h0, 0);

    // Asynchronous reset in the middle of a store, then a normal read.
    drv(0, 1, 1, 32'h70, 4'hF, 32'h55, 0, 0, 0, 32'h0);
    chk(1, 32'h0, 0, 0, 32'h60, 4'h0, 32'h0, 0);
    drv(1, 1, 0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 32'h0);
    chk(0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 0);
    idle_in(1, 0); chk(0, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 0);
    drv(0, 1, 0, 32'h80, 4'hF, 32'h0, 0, 0, 0, 32'h0);
    chk(1, 32'h0, 0, 0, 32'h0, 4'h0, 32'h0, 0);
    drv(0, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 1, 32'h0BADCAFE);
    chk(0, 32'h0BADCAFE, 1, 0, 32'h80, 4'hF, 32'h0, 0);
    idle_in(0, 0); chk(0, 32'h0, 0, 0, 32'h80, 4'h0, 32'h0, 0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expected vectors never checked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/data_bus_if.md
Name: data_bus_if

Overview:
- Sequential bus master between the MEM-stage load/store unit and the data memory, which sits behind a Wishbone-classic slave wrapper.
- Converts the single-cycle MEM-stage request (ce/we/addr/sel/data) into one registered Wishbone transaction.
- Holds the pipeline with a stall request until the transaction acknowledges or times out.
- Buffers read data across pipeline stalls and aborts the transaction on flush.

Parameters:
STALL_IDX, 4, bit of stall_i that freezes the MEM stage
TIMEOUT_CYCLES, 255, BUSY cycles without ack before forced termination (range 2..255)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
stall_i  input  6  pipeline stall vector
flush_i  input  1  pipeline flush; aborts any transaction
cpu_ce_i  input  1  MEM-stage memory request valid
cpu_we_i  input  1  1=store, 0=load
cpu_addr_i  input  32  byte address
cpu_sel_i  input  4  byte lane enables
cpu_data_i  input  32  store data
cpu_data_o  output  32  load data to MEM stage
stallreq  output  1  pipeline stall request
bus_err_o  output  1  one-cycle pulse on timeout
wb_ack_i  input  1  slave acknowledge
wb_data_i  input  32  slave read data
wb_addr_o  output  32  bus address (registered)
wb_data_o  output  32  bus write data (registered)
wb_we_o  output  1  bus write enable (registered)
wb_sel_o  output  4  bus byte select (registered)
wb_stb_o  output  1  strobe (registered)
wb_cyc_o  output  1  cycle (registered)

Behaviour:
- Reset:
  - State is IDLE.
  - All wb_* outputs, rd_buf, the timeout counter and bus_err_o are 0.
  - cpu_data_o and stallreq are 0.
- States: IDLE, BUSY, WAIT_STALL.
- IDLE:
  - When cpu_ce_i=1 and flush_i=0: next edge latches addr/data/we/sel into wb_*, sets cyc=stb=1, clears the counter and moves to BUSY.
  - stallreq = cpu_ce_i & ~flush_i, combinational in the same cycle.
  - cpu_data_o = 0.
- BUSY, evaluated in priority order:
  1. flush_i=1: next edge sets cyc=stb=we=sel=0 and rd_buf=0, moves to IDLE. stallreq=0.
  2. wb_ack_i=1:
     - Combinationally: stallreq=0; cpu_data_o = wb_data_i if wb_we_o=0, else 0.
     - Next edge: cyc=stb=we=sel=0; rd_buf captures wb_data_i on reads or 0 on writes.
     - Next state is WAIT_STALL if stall_i[STALL_IDX]=1, else IDLE.
  3. Counter = TIMEOUT_CYCLES-1 with no ack:
     - Combinationally: stallreq=0, cpu_data_o=0.
     - Next edge: terminate as for ack with rd_buf=0, bus_err_o=1 for exactly one cycle.
     - Next state follows the same stall rule as ack.
  4. Otherwise: stallreq=1, cpu_data_o=0, counter increments.
- WAIT_STALL:
  - stallreq=0, cpu_data_o=rd_buf, bus idle.
  - Moves to IDLE on the first edge with stall_i[STALL_IDX]=0.
  - New requests are ignored in this state.
- Timing:
  - Minimum read latency: request cycle, then first BUSY cycle (ack may arrive here).
  - A zero-wait slave costs exactly 1 stall cycle.
  - At most one outstanding transaction.
- wb_addr_o and the other wb_* outputs are held stable for the whole BUSY period.
- cpu_* inputs are sampled only on the IDLE→BUSY edge.
- Simultaneous events:
  - flush wins over ack.
  - ack wins over timeout.
  - A flush in IDLE or WAIT_STALL clears rd_buf and forces IDLE.
- Reset asserted mid-transaction drops cyc/stb immediately (asynchronous) without waiting for ack.

Test Plan:
- Read, ack on first BUSY cycle (slave returns 0xDEADBEEF), stall_i=0:
  - stallreq high 1 cycle.
  - cpu_data_o=0xDEADBEEF in the ack cycle.
  - cyc/stb low the following cycle, state IDLE.
- Store of 0x12345678 to addr 0x0000_0010, sel=0011, ack after 3 BUSY cycles:
  - wb_addr_o=0x10, wb_sel_o=0011, wb_we_o=1, all stable for 3 cycles.
  - stallreq high 3 cycles, cpu_data_o=0 throughout.
- Read 0xA5A5_0001 acked while stall_i[4]=1 for 4 further cycles:
  - State WAIT_STALL; cpu_data_o holds 0xA5A5_0001 all 4 cycles with stallreq=0.
  - IDLE after stall drops.
- flush_i asserted in the 2nd BUSY cycle, wb_ack_i also 1 in that cycle:
  - Flush wins: stallreq=0, cyc/stb=0 next edge, rd_buf=0, IDLE.
- No ack ever, TIMEOUT_CYCLES=4:
  - stallreq high exactly 4 cycles.
  - bus_err_o single-cycle pulse, cpu_data_o=0, cyc/stb drop.
- rst asserted asynchronously mid-BUSY:
  - All wb_* outputs and stallreq go 0 before the next clock edge.
  - After release, a new read completes normally.
